// File: rtl/acq_trig_pkg.sv
// Shared types and constants for the acquisition trigger controller.
// Imported by the AXI4-Lite top and its testbench.
package acq_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_RUN   = 2'd3
  } acq_state_t;

  // Byte offsets of the register map
  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_CFG    = 5'h04;
  localparam logic [4:0] ADDR_MASK   = 5'h08;
  localparam logic [4:0] ADDR_EDGE   = 5'h0C;
  localparam logic [4:0] ADDR_DELAY  = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h14;
  localparam logic [4:0] ADDR_TSTAMP = 5'h18;

  // CTRL pulse bits and CFG bits
  localparam int CTRL_ARM_BIT       = 0;
  localparam int CTRL_SOFT_BIT      = 1;
  localparam int CTRL_ABORT_BIT     = 2;
  localparam int CFG_AUTO_REARM_BIT = 0;

  // Source index reported when the software trigger fired
  localparam logic [3:0] SOFT_SRC = 4'hF;

  // Index of the lowest set bit; callers guarantee at least one bit is set
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/acq_trig_ctrl_axil_if.sv
// AXI4-Lite bus bundle for the acquisition trigger controller.
interface acq_trig_ctrl_axil_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic                            s_axi_awvalid;
  logic                            s_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                            s_axi_wvalid;
  logic                            s_axi_wready;
  logic [1:0]                      s_axi_bresp;
  logic                            s_axi_bvalid;
  logic                            s_axi_bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
  logic                            s_axi_arvalid;
  logic                            s_axi_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]                      s_axi_rresp;
  logic                            s_axi_rvalid;
  logic                            s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/acq_trig_sync_edge.sv
// One trigger channel: multi-flop synchroniser followed by a registered
// edge detector whose polarity is selectable (0 = rising, 1 = falling).
module acq_trig_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  input  logic i_falling,
  output logic o_hit
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_hit;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign o_hit  = r_hit;

  // Synchronise the input, remember its last value and register the edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_hit  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_sync;
      r_hit  <= i_falling ? (~w_sync & r_prev) : (w_sync & ~r_prev);
    end
  end

endmodule

// File: rtl/acq_trig_ctrl_axil.sv
// AXI4-Lite acquisition trigger controller: masked/polarity-selectable
// external triggers plus a software trigger, programmable start delay,
// and an arm/trigger/run/re-arm state machine.
// Optional feature macro: ACQ_TRIG_TIMESTAMP_EN (hit-cycle timestamp at 0x18).
module acq_trig_ctrl_axil
  import acq_trig_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_TRIG           = 4,
  parameter int DLY_WIDTH          = 32,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                ACLK,
  input  logic                ARESET,
  acq_trig_ctrl_axil_if.slave s_axi,
  input  logic [NUM_TRIG-1:0] trig_in,
  input  logic                acq_done,
  output logic                acq_start,
  output logic                acq_armed,
  output logic                acq_busy
);

  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] W_WORD_MASK = ~(C_S_AXI_ADDR_WIDTH'(3));

  // AXI handshake registers
  logic                          r_awready;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

  // Configuration registers and CTRL pulses
  logic                 r_auto_rearm;
  logic [NUM_TRIG-1:0]  r_mask;
  logic [NUM_TRIG-1:0]  r_edge;
  logic [DLY_WIDTH-1:0] r_delay;
  logic                 r_arm;
  logic                 r_soft;
  logic                 r_abort;

  // State machine registers
  acq_state_t           r_state;
  logic [DLY_WIDTH-1:0] r_cnt;
  logic [3:0]           r_src;
  logic [15:0]          r_count;
  logic                 r_start;
  logic                 r_armed;
  logic                 r_busy;
`ifdef ACQ_TRIG_TIMESTAMP_EN
  logic [31:0]          r_cyc;
  logic [31:0]          r_tstamp;
`endif

  logic                          w_wr_go;
  logic                          w_rd_go;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_waddr;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_raddr;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rdata;
  logic [NUM_TRIG-1:0]           w_chan_hit;
  logic [NUM_TRIG-1:0]           w_hits;
  logic                          w_hit;
  logic [3:0]                    w_src;

  assign w_wr_go = r_awready & s_axi.s_axi_awvalid & s_axi.s_axi_wvalid;
  assign w_rd_go = r_arready & s_axi.s_axi_arvalid;
  assign w_waddr = s_axi.s_axi_awaddr & W_WORD_MASK;
  assign w_raddr = s_axi.s_axi_araddr & W_WORD_MASK;

  assign s_axi.s_axi_awready = r_awready;
  assign s_axi.s_axi_wready  = r_awready;
  assign s_axi.s_axi_bvalid  = r_bvalid;
  assign s_axi.s_axi_bresp   = 2'b00;
  assign s_axi.s_axi_arready = r_arready;
  assign s_axi.s_axi_rvalid  = r_rvalid;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign s_axi.s_axi_rresp   = 2'b00;

  assign acq_start = r_start;
  assign acq_armed = r_armed;
  assign acq_busy  = r_busy;

  // Per-channel synchroniser and edge detector
  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_chan
    acq_trig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk       (ACLK),
      .rst       (ARESET),
      .i_async   (trig_in[g]),
      .i_falling (r_edge[g]),
      .o_hit     (w_chan_hit[g])
    );
  end

  // Software trigger wins the source field over any coinciding channel
  assign w_hits = w_chan_hit & r_mask;
  assign w_hit  = (|w_hits) | r_soft;
  assign w_src  = r_soft ? SOFT_SRC : lowest_set(16'(w_hits));

  // Write channel: accept AW+W together, store registers and raise CTRL pulses
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awready    <= 1'b0;
      r_bvalid     <= 1'b0;
      r_auto_rearm <= 1'b0;
      r_mask       <= '0;
      r_edge       <= '0;
      r_delay      <= '0;
      r_arm        <= 1'b0;
      r_soft       <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_awready <= s_axi.s_axi_awvalid & s_axi.s_axi_wvalid & ~r_bvalid & ~r_awready;
      r_arm     <= 1'b0;
      r_soft    <= 1'b0;
      r_abort   <= 1'b0;
      if (r_bvalid && s_axi.s_axi_bready) r_bvalid <= 1'b0;
      if (w_wr_go) begin
        r_bvalid <= 1'b1;
        if (w_waddr == C_S_AXI_ADDR_WIDTH'(ADDR_CTRL) && s_axi.s_axi_wstrb[0]) begin
          r_arm   <= s_axi.s_axi_wdata[CTRL_ARM_BIT];
          r_soft  <= s_axi.s_axi_wdata[CTRL_SOFT_BIT];
          r_abort <= s_axi.s_axi_wdata[CTRL_ABORT_BIT];
        end
        if (w_waddr == C_S_AXI_ADDR_WIDTH'(ADDR_CFG) && s_axi.s_axi_wstrb[0])
          r_auto_rearm <= s_axi.s_axi_wdata[CFG_AUTO_REARM_BIT];
        if (w_waddr == C_S_AXI_ADDR_WIDTH'(ADDR_MASK)) begin
          for (int i = 0; i < NUM_TRIG; i++)
            if (s_axi.s_axi_wstrb[i/8]) r_mask[i] <= s_axi.s_axi_wdata[i];
        end
        if (w_waddr == C_S_AXI_ADDR_WIDTH'(ADDR_EDGE)) begin
          for (int i = 0; i < NUM_TRIG; i++)
            if (s_axi.s_axi_wstrb[i/8]) r_edge[i] <= s_axi.s_axi_wdata[i];
        end
        if (w_waddr == C_S_AXI_ADDR_WIDTH'(ADDR_DELAY)) begin
          for (int i = 0; i < DLY_WIDTH; i++)
            if (s_axi.s_axi_wstrb[i/8]) r_delay[i] <= s_axi.s_axi_wdata[i];
        end
      end
    end
  end

  // Read data multiplexer; unmapped offsets and CTRL read as zero
  always_comb begin
    w_rdata = '0;
    case (w_raddr)
      C_S_AXI_ADDR_WIDTH'(ADDR_CFG):    w_rdata[CFG_AUTO_REARM_BIT] = r_auto_rearm;
      C_S_AXI_ADDR_WIDTH'(ADDR_MASK):   w_rdata[NUM_TRIG-1:0] = r_mask;
      C_S_AXI_ADDR_WIDTH'(ADDR_EDGE):   w_rdata[NUM_TRIG-1:0] = r_edge;
      C_S_AXI_ADDR_WIDTH'(ADDR_DELAY):  w_rdata[DLY_WIDTH-1:0] = r_delay;
      C_S_AXI_ADDR_WIDTH'(ADDR_STATUS): w_rdata[31:0] = {r_count, 8'h00, r_src, 2'b00, r_state};
`ifdef ACQ_TRIG_TIMESTAMP_EN
      C_S_AXI_ADDR_WIDTH'(ADDR_TSTAMP): w_rdata[31:0] = r_tstamp;
`endif
      default:                          w_rdata = '0;
    endcase
  end

  // Read channel: one-cycle arready, then hold rvalid with data until rready
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= s_axi.s_axi_arvalid & ~r_rvalid & ~r_arready;
      if (r_rvalid && s_axi.s_axi_rready) r_rvalid <= 1'b0;
      if (w_rd_go) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end
    end
  end

`ifdef ACQ_TRIG_TIMESTAMP_EN
  // Free-running cycle counter used to timestamp the hit
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_cyc <= '0;
    else        r_cyc <= r_cyc + 32'd1;
  end
`endif

  // Arm/trigger/delay/run state machine with registered status outputs; ABORT has top priority
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_src    <= '0;
      r_count  <= '0;
      r_start  <= 1'b0;
      r_armed  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef ACQ_TRIG_TIMESTAMP_EN
      r_tstamp <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      if (r_abort) begin
        r_state <= ST_IDLE;
        r_armed <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_arm) begin
              r_state <= ST_ARMED;
              r_armed <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (w_hit) begin
              r_state  <= ST_DELAY;
              r_armed  <= 1'b0;
              r_busy   <= 1'b1;
              r_cnt    <= r_delay;
              r_src    <= w_src;
              r_count  <= r_count + 16'd1;
`ifdef ACQ_TRIG_TIMESTAMP_EN
              r_tstamp <= r_cyc;
`endif
            end
          end
          ST_DELAY: begin
            if (r_cnt == '0) begin
              r_state <= ST_RUN;
              r_start <= 1'b1;
            end else begin
              r_cnt <= r_cnt - DLY_WIDTH'(1);
            end
          end
          ST_RUN: begin
            if (acq_done) begin
              r_busy <= 1'b0;
              if (r_auto_rearm) begin
                r_state <= ST_ARMED;
                r_armed <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_trig_ctrl_axil.sv
// Directed self-checking bench for acq_trig_ctrl_axil.
// Honours ACQ_TRIG_TIMESTAMP_EN when checking the TSTAMP register.
module tb_acq_trig_ctrl_axil;
  import acq_trig_pkg::*;

  localparam int NUM_TRIG    = 4;
  localparam int DLY_WIDTH   = 32;
  localparam int SYNC_STAGES = 2;

  logic                ACLK   = 1'b0;
  logic                ARESET = 1'b1;
  logic [NUM_TRIG-1:0] trig_in;
  logic                acq_done;
  logic                acq_start;
  logic                acq_armed;
  logic                acq_busy;

  int checks   = 0;
  int failures = 0;
  int tbCycle;

  acq_trig_ctrl_axil_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) axi ();

  acq_trig_ctrl_axil #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5),
    .NUM_TRIG           (NUM_TRIG),
    .DLY_WIDTH          (DLY_WIDTH),
    .SYNC_STAGES        (SYNC_STAGES)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .s_axi     (axi),
    .trig_in   (trig_in),
    .acq_done  (acq_done),
    .acq_start (acq_start),
    .acq_armed (acq_armed),
    .acq_busy  (acq_busy)
  );

  // 100 MHz clock
  always #5 ACLK = ~ACLK;

  // Bench-side count of clock edges since reset release
  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) tbCycle <= 0;
    else        tbCycle <= tbCycle + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit seen = 0;
    @(negedge ACLK);
    axi.s_axi_awaddr  = addr;
    axi.s_axi_awvalid = 1'b1;
    axi.s_axi_wdata   = data;
    axi.s_axi_wstrb   = strb;
    axi.s_axi_wvalid  = 1'b1;
    axi.s_axi_bready  = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ACLK);
      if (axi.s_axi_awready && axi.s_axi_wready) seen = 1;
    end
    checkOutput("aw_w_handshake", 32'(seen), 32'd1);
    @(negedge ACLK);
    axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wvalid  = 1'b0;
    checkOutput("bvalid_bresp", {29'd0, axi.s_axi_bvalid, axi.s_axi_bresp}, 32'h4);
  endtask

  task automatic axiRead(input logic [4:0] addr, output logic [31:0] data);
    bit seen = 0;
    @(negedge ACLK);
    axi.s_axi_araddr  = addr;
    axi.s_axi_arvalid = 1'b1;
    axi.s_axi_rready  = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ACLK);
      if (axi.s_axi_arready) seen = 1;
    end
    checkOutput("ar_handshake", 32'(seen), 32'd1);
    @(negedge ACLK);
    axi.s_axi_arvalid = 1'b0;
    data = axi.s_axi_rdata;
    checkOutput("rvalid_rresp", {29'd0, axi.s_axi_rvalid, axi.s_axi_rresp}, 32'h4);
  endtask

  task automatic readCheck(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] val;
    axiRead(addr, val);
    checkOutput(tag, val, exp);
  endtask

  // Drive trigger and done inputs just after a falling edge
  task automatic applyStimulus(input logic [NUM_TRIG-1:0] trigVal, input logic doneVal);
    @(negedge ACLK);
    trig_in  = trigVal;
    acq_done = doneVal;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge ACLK);
  endtask

  // Watch acq_start for a window; report the first negedge index it was high and pulse count
  task automatic watchStart(input int window, output int first, output int pulses);
    first  = 0;
    pulses = 0;
    for (int k = 1; k <= window; k++) begin
      @(negedge ACLK);
      if (acq_start) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
  endtask

  task automatic pulseDone();
    applyStimulus(trig_in, 1'b1);
    applyStimulus(trig_in, 1'b0);
  endtask

  // Directed test sequence
  initial begin
    int first;
    int pulses;
    int expTs;
    logic [31:0] tsVal;

    trig_in           = '0;
    acq_done          = 1'b0;
    axi.s_axi_awaddr  = '0;
    axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata   = '0;
    axi.s_axi_wstrb   = '0;
    axi.s_axi_wvalid  = 1'b0;
    axi.s_axi_bready  = 1'b0;
    axi.s_axi_araddr  = '0;
    axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready  = 1'b0;
    expTs             = 0;

    #200;
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("rst_outputs", {29'd0, acq_start, acq_armed, acq_busy}, 32'd0);
    checkOutput("rst_axi_ready_valid",
                {28'd0, axi.s_axi_awready, axi.s_axi_bvalid, axi.s_axi_arready, axi.s_axi_rvalid}, 32'd0);
    readCheck("rst_ctrl",   ADDR_CTRL,   32'd0);
    readCheck("rst_cfg",    ADDR_CFG,    32'd0);
    readCheck("rst_mask",   ADDR_MASK,   32'd0);
    readCheck("rst_edge",   ADDR_EDGE,   32'd0);
    readCheck("rst_delay",  ADDR_DELAY,  32'd0);
    readCheck("rst_status", ADDR_STATUS, 32'd0);
    readCheck("rst_tstamp", ADDR_TSTAMP, 32'd0);

    $display("[TB] single rising trigger on channel 1, DELAY=10");
    axiWrite(ADDR_MASK,  32'h2, 4'hF);
    axiWrite(ADDR_EDGE,  32'h0, 4'hF);
    axiWrite(ADDR_DELAY, 32'd10, 4'hF);
    axiWrite(ADDR_CTRL,  32'h1, 4'hF);
    readCheck("armed_status", ADDR_STATUS, 32'h0000_0001);
    checkOutput("armed_output", {30'd0, acq_armed, acq_busy}, 32'h2);
    applyStimulus(4'b0010, 1'b0);
    watchStart(40, first, pulses);
    // edge sampled at N, hit at N+3, start after edge N+14; the k-th negedge follows edge N+k-1
    checkOutput("ch1_start_latency", 32'(first), 32'(SYNC_STAGES + 1 + 10 + 1 + 1));
    checkOutput("ch1_start_pulses", 32'(pulses), 32'd1);
    checkOutput("run_busy", {30'd0, acq_armed, acq_busy}, 32'h1);
    readCheck("ch1_status_run", ADDR_STATUS, 32'h0001_0013);
    axiWrite(ADDR_CTRL, 32'h1, 4'hF);
    readCheck("arm_in_run_ignored", ADDR_STATUS, 32'h0001_0013);
    pulseDone();
    readCheck("ch1_status_idle", ADDR_STATUS, 32'h0001_0010);
    checkOutput("idle_outputs", {30'd0, acq_armed, acq_busy}, 32'h0);

    $display("[TB] edge outside ARMED is ignored");
    applyStimulus(4'b0000, 1'b0);
    idleCycles(6);
    applyStimulus(4'b0010, 1'b0);
    idleCycles(8);
    readCheck("hit_in_idle_ignored", ADDR_STATUS, 32'h0001_0010);

    $display("[TB] channel 0 rising and channel 2 falling in one cycle");
    applyStimulus(4'b0000, 1'b0);
    axiWrite(ADDR_MASK, 32'h5, 4'hF);
    axiWrite(ADDR_EDGE, 32'h4, 4'hF);
    applyStimulus(4'b0100, 1'b0);
    idleCycles(6);
    axiWrite(ADDR_CTRL, 32'h1, 4'hF);
    applyStimulus(4'b0001, 1'b0);
    watchStart(40, first, pulses);
    checkOutput("multi_start_latency", 32'(first), 32'(SYNC_STAGES + 1 + 10 + 1 + 1));
    checkOutput("multi_start_pulses", 32'(pulses), 32'd1);
    readCheck("multi_status_run", ADDR_STATUS, 32'h0002_0003);
    pulseDone();
    readCheck("multi_status_idle", ADDR_STATUS, 32'h0002_0000);

    $display("[TB] auto re-arm with three software triggers, DELAY=3");
    axiWrite(ADDR_CFG,   32'h1, 4'hF);
    axiWrite(ADDR_DELAY, 32'd3, 4'hF);
    axiWrite(ADDR_CTRL,  32'h1, 4'hF);
    for (int r = 0; r < 3; r++) begin
      axiWrite(ADDR_CTRL, 32'h2, 4'hF);
      // the soft pulse is live in the cycle after acceptance, whose counter value equals tbCycle here
      expTs = tbCycle;
      watchStart(12, first, pulses);
      checkOutput("soft_start_latency", 32'(first), 32'd5);
      checkOutput("soft_start_pulses", 32'(pulses), 32'd1);
      pulseDone();
      checkOutput("soft_rearmed", {30'd0, acq_armed, acq_busy}, 32'h2);
      axiRead(ADDR_TSTAMP, tsVal);
`ifdef ACQ_TRIG_TIMESTAMP_EN
      checkOutput("tstamp_hit_cycle", tsVal, 32'(expTs));
`else
      checkOutput("tstamp_disabled", tsVal, 32'd0);
`endif
    end
    readCheck("soft_status", ADDR_STATUS, 32'h0005_00F1);

    $display("[TB] ABORT beats a same-cycle software trigger, DELAY=0");
    axiWrite(ADDR_DELAY, 32'd0, 4'hF);
    axiWrite(ADDR_CTRL, 32'h6, 4'hF);
    watchStart(8, first, pulses);
    checkOutput("abort_soft_pulses", 32'(pulses), 32'd0);
    readCheck("abort_soft_status", ADDR_STATUS, 32'h0005_00F0);

    $display("[TB] ABORT beats a same-cycle channel 0 hit");
    applyStimulus(4'b0000, 1'b0);
    idleCycles(6);
    axiWrite(ADDR_MASK, 32'h1, 4'hF);
    axiWrite(ADDR_EDGE, 32'h0, 4'hF);
    axiWrite(ADDR_CTRL, 32'h1, 4'hF);
    readCheck("rearm_status", ADDR_STATUS, 32'h0005_00F1);
    // edge sampled one cycle before the write is driven lands its hit in the ABORT cycle
    applyStimulus(4'b0001, 1'b0);
    axiWrite(ADDR_CTRL, 32'h4, 4'hF);
    watchStart(10, first, pulses);
    checkOutput("abort_ext_pulses", 32'(pulses), 32'd0);
    readCheck("abort_ext_status", ADDR_STATUS, 32'h0005_00F0);

    $display("[TB] byte strobes and unmapped addresses");
    axiWrite(ADDR_DELAY, 32'hAABB_CCDD, 4'h5);
    readCheck("delay_wstrb", ADDR_DELAY, 32'h00BB_00DD);
    axiWrite(ADDR_MASK, 32'hF, 4'h0);
    readCheck("mask_no_strb", ADDR_MASK, 32'h1);
    axiWrite(5'h1C, 32'hFFFF_FFFF, 4'hF);
    readCheck("unmapped_read", 5'h1C, 32'd0);
    readCheck("ctrl_reads_zero", ADDR_CTRL, 32'd0);
    readCheck("cfg_readback", ADDR_CFG, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
